// File: rtl/dma_burst_writer.sv
// Capture-to-Avalon burst writer: packs 32-bit words into 128-bit beats, queues them in a
// beat FIFO and drains them as Avalon-MM write bursts, with a flush path for partial data.
module dma_burst_writer #(
    parameter int AW    = 23,
    parameter int BURST = 32,
    parameter int DEPTH = 64
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [31:0]   d,
    input  logic          dv,
    input  logic          flush,
    output logic          flush_complete,
    output logic          overflow,
    output logic          busy,
    output logic          txs_write,
    output logic [127:0]  txs_writedata,
    output logic [5:0]    txs_burstcount,
    output logic [AW-1:0] txs_address,
    input  logic          txs_waitrequest
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] BURST_C   = CW'(BURST);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);
    localparam logic [5:0]    BURST_BC  = 6'(BURST);
    localparam logic [PW-1:0] PTR_ONE   = {{(PW - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_MASK = {{(AW - 4){1'b1}}, 4'b0000};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_BURST = 3'd2,
        S_PAD   = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     pk_cnt_q, pk_cnt_d;
    logic [95:0]    pk_data_q, pk_data_d;
    logic [127:0]   beat_q, beat_d;
    logic           beat_vld_q, beat_vld_d;
    logic [127:0]   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_s;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW:0]    occ_s;
    logic           flush_lat_q, flush_lat_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [5:0]     bc_q, bc_d, left_q, left_d, bc_new_s;
    logic [127:0]   wdata_q, wdata_d, push_data_s;
    logic           write_q, write_d, busy_q, busy_d, fc_q, fc_d, ovf_q, ovf_d;
    logic           take_s, clr_s, full_s, pop_s, last_s, pad_s, push_s, enter_s;

    // Shared control strobes: word acceptance, FIFO push/pop and burst completion.
    always_comb begin
        take_s      = dv && ((state_q == S_IDLE) || (state_q == S_ARM) || (state_q == S_BURST));
        clr_s       = (state_q == S_IDLE) && start;
        // A beat still waiting in the packer output already owns a FIFO slot.
        occ_s       = {1'b0, cnt_q} + {{CW{1'b0}}, beat_vld_q};
        full_s      = (occ_s >= DEPTH_C);
        pop_s       = (state_q == S_BURST) && write_q && !txs_waitrequest;
        last_s      = pop_s && (left_q == 6'd1);
        pad_s       = (state_q == S_PAD) && (pk_cnt_q != 2'd0) && !full_s;
        push_s      = !clr_s && (beat_vld_q || pad_s);
        push_data_s = beat_vld_q ? beat_q : {32'h0000_0000, pk_data_q};
        rd_nxt_s    = rd_ptr_q + PTR_ONE;
        bc_new_s    = (cnt_q >= BURST_C) ? BURST_BC : 6'(cnt_q);
    end

    // Word packer and sticky overflow.
    always_comb begin
        pk_cnt_d   = pk_cnt_q;
        pk_data_d  = pk_data_q;
        beat_d     = beat_q;
        beat_vld_d = 1'b0;
        ovf_d      = ovf_q;
        if (clr_s) begin
            pk_cnt_d  = 2'd0;
            pk_data_d = 96'd0;
            ovf_d     = 1'b0;
        end else if (take_s) begin
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                pk_cnt_d = pk_cnt_q + 2'd1;
                case (pk_cnt_q)
                    2'd0: pk_data_d[31:0]  = d;
                    2'd1: pk_data_d[63:32] = d;
                    2'd2: pk_data_d[95:64] = d;
                    2'd3: begin
                        beat_d     = {d, pk_data_q};
                        beat_vld_d = 1'b1;
                        pk_data_d  = 96'd0;
                    end
                    default: pk_data_d = pk_data_q;
                endcase
            end
        end else if (state_q == S_PAD) begin
            pk_cnt_d  = 2'd0;
            pk_data_d = 96'd0;
        end else begin
            pk_cnt_d = pk_cnt_q;
        end
    end

    // Beat FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_s) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_nxt_s;
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Flush request latch; ignored while idle, consumed in DONE.
    always_comb begin
        if ((state_q == S_IDLE) || (state_q == S_DONE)) flush_lat_d = 1'b0;
        else if (flush)                                  flush_lat_d = 1'b1;
        else                                             flush_lat_d = flush_lat_q;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ARM; else state_d = S_IDLE;
            S_ARM: begin
                if (cnt_q >= BURST_C)  state_d = S_BURST;
                else if (flush_lat_q)  state_d = S_PAD;
                else                   state_d = S_ARM;
            end
            // A flush after a burst still pads, so words taken during the burst are not stranded.
            S_BURST: begin
                if (last_s && flush_lat_q) state_d = S_PAD;
                else if (last_s)           state_d = S_ARM;
                else                       state_d = S_BURST;
            end
            S_PAD:   state_d = S_FLUSH;
            S_FLUSH: if (cnt_q == {CW{1'b0}}) state_d = S_DONE; else state_d = S_BURST;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and burst bookkeeping, all captured into flops.
    always_comb begin
        enter_s = (state_d == S_BURST) && (state_q != S_BURST);
        write_d = (state_d == S_BURST);
        busy_d  = (state_d != S_IDLE);
        fc_d    = (state_d == S_DONE);
        bc_d    = bc_q;
        left_d  = left_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        if (clr_s) begin
            addr_d = base & ADDR_MASK;
        end else if (enter_s) begin
            bc_d    = bc_new_s;
            left_d  = bc_new_s;
            wdata_d = mem_q[rd_ptr_q];
        end else if (last_s) begin
            left_d  = 6'd0;
            wdata_d = 128'd0;
            addr_d  = addr_q + (AW'(bc_q) << 4);
        end else if (pop_s) begin
            // Every beat of the burst was already in the FIFO when it began.
            left_d  = left_q - 6'd1;
            wdata_d = mem_q[rd_nxt_s];
        end else begin
            left_d = left_q;
        end
    end

    // State register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pk_cnt_q    <= 2'd0;
            pk_data_q   <= 96'd0;
            beat_q      <= 128'd0;
            beat_vld_q  <= 1'b0;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            flush_lat_q <= 1'b0;
            addr_q      <= {AW{1'b0}};
            bc_q        <= 6'd0;
            left_q      <= 6'd0;
            wdata_q     <= 128'd0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            fc_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pk_cnt_q    <= pk_cnt_d;
            pk_data_q   <= pk_data_d;
            beat_q      <= beat_d;
            beat_vld_q  <= beat_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            flush_lat_q <= flush_lat_d;
            addr_q      <= addr_d;
            bc_q        <= bc_d;
            left_q      <= left_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            fc_q        <= fc_d;
            ovf_q       <= ovf_d;
        end
    end

    // Beat storage; validity is tracked by the pointers.
    always_ff @(posedge c) begin
        if (push_s) mem_q[wr_ptr_q] <= push_data_s;
    end

    assign txs_write      = write_q;
    assign txs_writedata  = wdata_q;
    assign txs_burstcount = bc_q;
    assign txs_address    = addr_q;
    assign busy           = busy_q;
    assign flush_complete = fc_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_dma_burst_writer.sv
// Directed bench for dma_burst_writer: a queue-based model of beats and bursts is checked
// against the Avalon master every cycle, plus literal expectations for key scenarios.
module tb_dma_burst_writer;
    localparam int AW = 23;

    logic          c, rst_n, start, dv, flush, wreq;
    logic [AW-1:0] base;
    logic [31:0]   d;
    logic          flush_complete, overflow, busy, txs_write;
    logic [127:0]  txs_writedata;
    logic [5:0]    txs_burstcount;
    logic [AW-1:0] txs_address;

    int checks = 0;
    int errors = 0;
    int wmode  = 0;
    bit chk_en = 1'b0;

    logic [127:0]  exp_beats[$];
    int            exp_sizes[$];
    logic [AW-1:0] exp_addrs[$];
    logic [31:0]   pend_words[$];
    logic [AW-1:0] addr_log[$];
    int            size_log[$];
    int            cur_left = 0;
    int            cur_size = 0;
    logic [AW-1:0] cur_addr = '0;
    int            beat_count = 0;
    int            fc_count = 0;
    logic [127:0]  first_beat = '0;
    logic [127:0]  last_beat = '0;

    dma_burst_writer #(.AW(AW), .BURST(32), .DEPTH(64)) dut (
        .c(c), .rst_n(rst_n), .start(start), .base(base), .d(d), .dv(dv), .flush(flush),
        .flush_complete(flush_complete), .overflow(overflow), .busy(busy),
        .txs_write(txs_write), .txs_writedata(txs_writedata), .txs_burstcount(txs_burstcount),
        .txs_address(txs_address), .txs_waitrequest(wreq)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge c);
        #1;
    endtask

    // Model: words -> beats, beat count -> burst plan
    task automatic model_word(input logic [31:0] w);
        pend_words.push_back(w);
        if (pend_words.size() == 4) begin
            exp_beats.push_back({pend_words[3], pend_words[2], pend_words[1], pend_words[0]});
            pend_words.delete();
        end
    endtask

    task automatic model_pad;
        if (pend_words.size() != 0) begin
            while (pend_words.size() < 4) pend_words.push_back(32'h0);
            exp_beats.push_back({pend_words[3], pend_words[2], pend_words[1], pend_words[0]});
            pend_words.delete();
        end
    endtask

    task automatic model_plan(input logic [AW-1:0] b, input int nbeats);
        logic [AW-1:0] a;
        int rem, sz;
        a = b & 23'h7FFFF0;
        rem = nbeats;
        while (rem > 0) begin
            sz = (rem >= 32) ? 32 : rem;
            exp_sizes.push_back(sz);
            exp_addrs.push_back(a);
            a = a + 23'(16 * sz);
            rem = rem - sz;
        end
    endtask

    // Stall generator: 0 never, 1 random 50%, 2 always.
    initial begin
        wreq = 1'b0;
        forever begin
            @(posedge c);
            #1;
            if (wmode == 1) wreq = ($urandom_range(0, 1) == 1);
            else            wreq = (wmode == 2);
        end
    end

    // Compare process: every cycle with txs_write high is checked against the model.
    always @(negedge c) begin
        if (rst_n && chk_en) begin
            if (flush_complete) fc_count++;
            if (txs_write) begin
                if (cur_left == 0) begin
                    if (exp_sizes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_burst: got write at %h required no write", txs_address);
                    end else begin
                        cur_size = exp_sizes.pop_front();
                        cur_left = cur_size;
                        cur_addr = exp_addrs.pop_front();
                        addr_log.push_back(txs_address);
                        size_log.push_back(int'(txs_burstcount));
                    end
                end
                if (cur_left != 0) begin
                    chk("burst_address", txs_address, cur_addr);
                    chk("burstcount", txs_burstcount, cur_size);
                    if (exp_beats.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got %h required none", txs_writedata);
                    end else begin
                        chk("beat_data", txs_writedata, exp_beats[0]);
                        if (!wreq) begin
                            if (beat_count == 0) first_beat = txs_writedata;
                            last_beat = txs_writedata;
                            beat_count++;
                            void'(exp_beats.pop_front());
                            cur_left--;
                        end
                    end
                end
            end else if (cur_left != 0) begin
                checks++;
                errors++;
                $display("FAIL burst_interrupted: got write=0 required %0d more beats", cur_left);
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b);
        pend_words.delete();
        addr_log.delete();
        size_log.delete();
        beat_count = 0;
        fc_count = 0;
        base = b;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit flush_last, input int model_limit);
        for (int i = 0; i < n; i++) begin
            d = 32'(i);
            dv = 1'b1;
            flush = flush_last && (i == n - 1);
            if (i < model_limit) model_word(32'(i));
            tick;
        end
        dv = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick;
        flush = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_sizes.size() != 0 || cur_left != 0) && n < budget) begin
            tick;
            n++;
        end
        chk(name, (n >= budget), 1'b0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick;
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        int guard;
        int fcb;
        rst_n = 1'b0; start = 1'b0; dv = 1'b0; flush = 1'b0; base = '0; d = '0;
        repeat (3) @(posedge c);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_write", txs_write, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_flush_complete", flush_complete, 1'b0);
        chk("rst_address", txs_address, 23'h0);
        chk("rst_burstcount", txs_burstcount, 6'd0);
        chk("rst_writedata", txs_writedata, 128'h0);
        rst_n = 1'b1;
        tick;
        chk_en = 1'b1;

        // Streaming, no stalls: two full bursts
        wmode = 0;
        do_start(23'h001000);
        chk("start_busy", busy, 1'b1);
        model_plan(23'h001000, 64);
        chk("model_second_addr", exp_addrs[1], 23'h001200);
        send_words(256, 1'b0, 256);
        chk("model_beat0", {32'h3, 32'h2, 32'h1, 32'h0}, 128'h00000003_00000002_00000001_00000000);
        wait_drained("drain_stream", 400);
        chk("stream_bursts", addr_log.size(), 2);
        chk("stream_addr0", addr_log[0], 23'h001000);
        chk("stream_addr1", addr_log[1], 23'h001200);
        chk("stream_bc0", size_log[0], 32);
        chk("stream_beat0", first_beat, 128'h00000003_00000002_00000001_00000000);
        chk("stream_beats", beat_count, 64);
        do_flush;
        wait_idle("stream_idle", 50);
        chk("stream_fc_once", fc_count, 1);

        // Same stream with random stalls
        wmode = 1;
        do_start(23'h001000);
        model_plan(23'h001000, 64);
        send_words(256, 1'b0, 256);
        wait_drained("drain_random", 2000);
        chk("random_beats", beat_count, 64);
        chk("random_addr1", addr_log[1], 23'h001200);
        chk("random_last_beat", last_beat, {32'd255, 32'd254, 32'd253, 32'd252});
        wmode = 0;
        do_flush;
        wait_idle("random_idle", 50);

        // 10 words, flush together with the last word
        do_start(23'h002000);
        model_plan(23'h002000, 3);
        send_words(10, 1'b1, 10);
        model_pad;
        wait_idle("flush_idle", 200);
        wait_drained("drain_flush", 10);
        chk("flush_bc", size_log[0], 3);
        chk("flush_last_beat", last_beat, 128'h00000000_00000000_00000009_00000008);
        chk("flush_fc_once", fc_count, 1);
        chk("flush_beats", beat_count, 3);

        // Flush in IDLE is ignored
        fcb = fc_count;
        do_flush;
        repeat (5) tick;
        chk("idle_flush_no_fc", fc_count, fcb);
        chk("idle_flush_busy", busy, 1'b0);

        // Overflow with the slave stalled
        wmode = 2;
        do_start(23'h004000);
        model_plan(23'h004000, 64);
        send_words(256, 1'b0, 256);
        tick;
        chk("ovf_before_drop", overflow, 1'b0);
        send_words(1, 1'b0, 0);
        d = 32'd256; dv = 1'b1; tick; dv = 1'b0;
        tick;
        chk("ovf_set", overflow, 1'b1);
        wmode = 0;
        do_flush;
        wait_idle("ovf_idle", 400);
        wait_drained("drain_ovf", 10);
        chk("ovf_beats", beat_count, 64);
        chk("ovf_sticky", overflow, 1'b1);
        chk("ovf_fc_once", fc_count, 1);

        // Address wrap
        do_start(23'h7FFE00);
        chk("ovf_cleared_by_start", overflow, 1'b0);
        model_plan(23'h7FFE00, 64);
        chk("model_wrap_addr", exp_addrs[1], 23'h000000);
        send_words(256, 1'b0, 256);
        wait_drained("drain_wrap", 400);
        chk("wrap_addr0", addr_log[0], 23'h7FFE00);
        chk("wrap_addr1", addr_log[1], 23'h000000);
        do_flush;
        wait_idle("wrap_idle", 50);

        // Reset in the middle of a burst
        do_start(23'h003000);
        model_plan(23'h003000, 32);
        send_words(128, 1'b0, 128);
        guard = 0;
        while (beat_count < 5 && guard < 200) begin
            tick;
            guard++;
        end
        chk("reset_reach_beat5", (beat_count >= 5), 1'b1);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_write_low", txs_write, 1'b0);
        chk("async_busy_low", busy, 1'b0);
        chk("async_writedata", txs_writedata, 128'h0);
        exp_beats.delete();
        exp_sizes.delete();
        exp_addrs.delete();
        cur_left = 0;
        repeat (3) @(posedge c);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (40) tick;
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_write", txs_write, 1'b0);
        chk("post_reset_bc", txs_burstcount, 6'd0);
        do_start(23'h005000);
        do_flush;
        wait_idle("empty_flush_idle", 50);
        chk("empty_flush_fc", fc_count, 1);
        chk("empty_flush_beats", beat_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
